// File: rtl/riscv_pkg.sv
// Shared core-wide constants and the fetch buffer entry layout.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock in-order FIFO with flush; power-of-two depth so pointers wrap naturally.
module fifo_sync #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero before any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited word fetches, in-order response buffer, redirect flush/drop.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               areset,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            fifo_empty;
    logic            fifo_full;
    logic            accept;
    logic            rsp_ok;
    logic            keep;
    logic            pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    // Buffered plus in-flight words never exceed DEPTH, so a kept response always fits.
    assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign mem_req_valid = areset && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is stray and must not touch state.
    assign rsp_ok           = mem_rsp_valid && (outstanding != '0);
    assign keep             = rsp_ok && (drop == '0) && !redirect_valid;
    assign outstanding_next = outstanding + CW'(accept) - CW'(rsp_ok);
    assign target           = align_pc(redirect_pc);

    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign instr       = fifo_empty ? '0 : head.instr;
    assign instr_pc    = fifo_empty ? '0 : head.pc;

    assign wr_entry.pc    = rsp_pc;
    assign wr_entry.instr = mem_rsp_data;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Every unanswered request, including one accepted this cycle, is stale.
                fetch_pc <= target;
                rsp_pc   <= target;
                drop     <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_STEP;
                if (keep)   rsp_pc   <= rsp_pc + PC_STEP;
                if (rsp_ok && (drop != '0)) drop <= drop - 1'b1;
            end
        end
    end

    fifo_sync #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (areset),
        .push   (keep),
        .pop    (pop),
        .flush  (redirect_valid),
        .wr_data(wr_entry),
        .rd_data(head),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    no_overflow: assert property (@(posedge clk) disable iff (!areset)
        !(keep && fifo_full && !pop));

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage upstream of the single-cycle core's decode/execute path.
- Issues word fetches to a request/response instruction memory port.
- Buffers returned words, with their PCs, in a small in-order FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects (taken branch/jump) by flushing the buffer and discarding in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding-plus-buffered fetches (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- areset  in  1  asynchronous active-low reset
- mem_req_valid  out  1  fetch request present this cycle
- mem_req_ready  in  1  memory accepts request this cycle
- mem_req_addr  out  32  word-aligned fetch address
- mem_rsp_valid  in  1  response word valid, in request order
- mem_rsp_data  in  32  returned instruction word
- redirect_valid  in  1  control-flow change from execute
- redirect_pc  in  32  new fetch target
- instr_valid  out  1  buffered instruction available
- instr_ready  in  1  decode consumes instruction
- instr  out  32  instruction at FIFO head
- instr_pc  out  32  PC of instr

Behaviour:
- Reset (areset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - Outputs: instr_valid=0, instr=0, instr_pc=0, mem_req_addr=RESET_PC.
  - mem_req_valid=0 while areset=0.
  - Reset mid-operation discards everything, including in-flight responses; the drop count is cleared, not preserved.
- Request side:
  - mem_req_valid = areset && (count + outstanding < DEPTH); mem_req_addr = fetch_pc.
  - The port has no payload-stability rule. A request is accepted only in a cycle with valid && ready.
  - On accept: fetch_pc += 4, wrapping modulo 2^32; outstanding += 1.
- Response side:
  - Responses arrive in order, at least 1 cycle after acceptance.
  - Each response decrements outstanding.
  - If drop>0 or redirect_valid is high, the response is discarded and drop decrements (if >0). Otherwise {data, pc} is pushed, with pc taken from an internal rsp_pc counter that advances by 4 per kept response.
  - mem_rsp_valid with outstanding=0 is a protocol error and is ignored (no state change).
- Decode side:
  - instr_valid = FIFO not empty; instr/instr_pc come from the FIFO head.
  - Pop on instr_valid && instr_ready. Push and pop may occur in the same cycle.
  - Overflow is impossible by credit accounting (count + outstanding ≤ DEPTH always).
- Redirect (redirect_valid=1), applied at the clock edge; it takes priority over all other events in that cycle:
  - FIFO cleared (a same-cycle pop counts as consumed).
  - fetch_pc and rsp_pc set to {redirect_pc[31:2],2'b00}; the low two bits are ignored.
  - drop set to outstanding_next, i.e. all requests not yet answered, including one accepted in this same cycle.
  - The first post-redirect request is issued the following cycle if credit allows.
- Latency: request accepted in cycle N and responded in N+1 → instr_valid in N+2. Sustained throughput is 1 instr/cycle with single-cycle memory and decode always ready.
- Widths: count, outstanding and drop are $clog2(DEPTH+1) bits; all PC arithmetic is 32-bit unsigned.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32, INSTR_W=32
  - PC_STEP=4
  - NOP_INSTR=32'h0000_0013 (used by the core for an empty-fetch bubble)
- One natural sub-module: fifo_sync.
  - Parameterised width/depth, async active-low reset, push/pop/flush.
  - Exposes count, empty, full.
  - Instantiated with width 64 for {pc, instr}.

Test Plan:
1. Reset release, memory always ready, 1-cycle response, decode ready → instr_pc sequence 0,4,8,12 with mem data 0xA0..0xA3; first instr_valid 2 cycles after first accept.
2. Decode instr_ready=0, memory ready → exactly DEPTH=4 requests issued, then mem_req_valid=0; FIFO holds PCs 0..12; raising instr_ready resumes fetch at 16.
3. Memory latency 3 cycles with 2 outstanding; redirect_valid with redirect_pc=0x103 → both late responses dropped; next request addr 0x100; first delivered instr_pc=0x100.
4. Redirect in the same cycle as a response and a pop → response discarded, FIFO empty next cycle, fetch_pc=redirect target.
5. areset pulsed low mid-burst with 2 outstanding → outputs zero immediately (asynchronous); after release, fetch restarts at RESET_PC and any stray responses are ignored while outstanding=0.
6. redirect_pc=0xFFFF_FFFC → fetch addresses 0xFFFF_FFFC then 0x0000_0000 (wrap).
